// File: rtl/ahb_decode_pkg.sv
// Shared constants and types for the AHB address decoder / response mux
// and its built-in default slave.
package ahb_decode_pkg;

  localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK    = 32'hFFFF_0000;
  localparam logic [31:0] RAM_BASE    = 32'h2000_0000;
  localparam logic [31:0] RAM_MASK    = 32'hFFFF_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
  localparam logic [31:0] PERIPH_MASK = 32'hFFFF_F000;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam int NUM_SLAVES = 3;

  typedef enum logic [1:0] {
    SLV_ROM     = 2'd0,
    SLV_RAM     = 2'd1,
    SLV_PERIPH  = 2'd2,
    SLV_DEFAULT = 2'd3
  } slave_idx_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  function automatic slave_idx_e decode_addr(input logic [31:0] addr);
    if ((addr & ROM_MASK) == ROM_BASE)       return SLV_ROM;
    if ((addr & RAM_MASK) == RAM_BASE)       return SLV_RAM;
    if ((addr & PERIPH_MASK) == PERIPH_BASE) return SLV_PERIPH;
    return SLV_DEFAULT;
  endfunction

  // Only NONSEQ/SEQ carry a real transfer that an unmapped slave must reject.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_decode_mux_if.sv
// Bus bundle between the AHB master, the three slaves and the decoder/mux.
// The decoder uses the slave modport; the master side drives the other end.
interface ahb_decode_mux_if;

  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsel;
  logic        hready;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic [95:0] s_hrdata;
  logic [2:0]  s_hready_resp;
  logic [5:0]  s_hresp;

  modport slave (
    input  haddr, htrans, s_hrdata, s_hready_resp, s_hresp,
    output hsel, hready, hrdata, hresp
  );

  modport master (
    output haddr, htrans, s_hrdata, s_hready_resp, s_hresp,
    input  hsel, hready, hrdata, hresp
  );

endinterface

// File: rtl/ahb_default_slave.sv
// Default-slave FSM producing the two-cycle ERROR response for unmapped transfers.
// With AHB_DECODE_MUX_TIMEOUT_EN defined, a stalled mapped data phase is also forced to ERROR.
module ahb_default_slave
  import ahb_decode_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      hready,
  input  logic      unmapped_req,
  input  logic      stall,
  output ds_state_e state,
  output logic      timeout
);

  ds_state_e state_q, state_d;

`ifdef AHB_DECODE_MUX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Fires on the cycle that completes the TIMEOUT_CYCLES-th stalled cycle.
  always_comb begin
    count_d = count_q;
    timeout = 1'b0;
    if (hready) begin
      count_d = '0;
    end else if (stall) begin
      if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = stall & (TIMEOUT_CYCLES > 0);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (timeout || (hready && unmapped_req)) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = unmapped_req ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= DS_IDLE;
    else        state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/ahb_decode_mux.sv
// AHB address decoder and data-phase response mux for ROM/RAM/PERIPH plus a default slave.
// Optional stall watchdog enabled by defining AHB_DECODE_MUX_TIMEOUT_EN.
module ahb_decode_mux
  import ahb_decode_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_decode_mux_if.slave  bus
);

  slave_idx_e  addr_sel;
  slave_idx_e  dsel_q, dsel_d;
  ds_state_e   ds_state;
  logic        timeout;
  logic        unmapped_req;
  logic        stall;
  logic [2:0]  hsel_dec;
  logic        hready_mux;
  logic [1:0]  hresp_mux;
  logic [31:0] hrdata_mux;

  assign addr_sel     = decode_addr(bus.haddr);
  assign unmapped_req = (addr_sel == SLV_DEFAULT) && is_active(bus.htrans);

  always_comb begin
    hsel_dec = 3'b000;
    case (addr_sel)
      SLV_ROM:    hsel_dec = 3'b001;
      SLV_RAM:    hsel_dec = 3'b010;
      SLV_PERIPH: hsel_dec = 3'b100;
      default:    hsel_dec = 3'b000;
    endcase
  end

  // Error states own the bus; otherwise the registered data-phase slave drives it.
  always_comb begin
    hready_mux = 1'b1;
    hresp_mux  = HRESP_OKAY;
    hrdata_mux = '0;
    case (ds_state)
      DS_ERR1: begin
        hready_mux = 1'b0;
        hresp_mux  = HRESP_ERROR;
      end
      DS_ERR2: hresp_mux = HRESP_ERROR;
      default: begin
        case (dsel_q)
          SLV_ROM: begin
            hready_mux = bus.s_hready_resp[0];
            hresp_mux  = bus.s_hresp[1:0];
            hrdata_mux = bus.s_hrdata[31:0];
          end
          SLV_RAM: begin
            hready_mux = bus.s_hready_resp[1];
            hresp_mux  = bus.s_hresp[3:2];
            hrdata_mux = bus.s_hrdata[63:32];
          end
          SLV_PERIPH: begin
            hready_mux = bus.s_hready_resp[2];
            hresp_mux  = bus.s_hresp[5:4];
            hrdata_mux = bus.s_hrdata[95:64];
          end
          default: ;
        endcase
      end
    endcase
  end

  assign stall = (dsel_q != SLV_DEFAULT) && (ds_state == DS_IDLE) && !hready_mux;

  // A timed-out slave is detached so its late response cannot reach the master.
  always_comb begin
    dsel_d = dsel_q;
    if (timeout)         dsel_d = SLV_DEFAULT;
    else if (hready_mux) dsel_d = addr_sel;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) dsel_q <= SLV_DEFAULT;
    else          dsel_q <= dsel_d;
  end

  ahb_default_slave #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_default_slave (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .hready       (hready_mux),
    .unmapped_req (unmapped_req),
    .stall        (stall),
    .state        (ds_state),
    .timeout      (timeout)
  );

  assign bus.hsel   = hsel_dec;
  assign bus.hready = hready_mux;
  assign bus.hresp  = hresp_mux;
  assign bus.hrdata = hrdata_mux;

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Testbench for ahb_decode_mux: directed bus scenarios plus randomized traffic
// checked against a transfer-level reference model.
module tb_ahb_decode_mux;

  localparam int TB_TIMEOUT = 8;

  logic HCLK = 1'b0;
  logic HRESETn;
  int   checks = 0;
  int   errors = 0;

  // Reference model: which slave owns the data phase (-1 = none), how many
  // ERROR-response cycles remain, and how long the current slave has stalled.
  int          m_dslave   = -1;
  int          m_err_left = 0;
  int          m_stall    = 0;
  logic [2:0]  exp_hsel;
  logic        exp_hready;
  logic [1:0]  exp_hresp;
  logic [31:0] exp_hrdata;

  ahb_decode_mux_if bus ();

  ahb_decode_mux #(
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  function automatic int ref_decode(input logic [31:0] a);
    if (a <= 32'h0000_FFFF)                         return 0;
    if (a >= 32'h2000_0000 && a <= 32'h2000_FFFF)   return 1;
    if (a >= 32'h4000_0000 && a <= 32'h4000_0FFF)   return 2;
    return -1;
  endfunction

  // Drives one bus cycle at the falling edge, predicts this cycle's outputs,
  // then advances the model across the following rising edge.
  task automatic apply_cycle(input logic rstn, input logic [31:0] addr, input logic [1:0] trans,
                             input logic [2:0] rdy, input logic [5:0] resp, input logic [95:0] rdata);
    int idx;
    @(negedge HCLK);
    HRESETn           = rstn;
    bus.haddr         = addr;
    bus.htrans        = trans;
    bus.s_hready_resp = rdy;
    bus.s_hresp       = resp;
    bus.s_hrdata      = rdata;
    #1;
    idx = ref_decode(addr);
    exp_hsel = (idx == 0) ? 3'b001 : (idx == 1) ? 3'b010 : (idx == 2) ? 3'b100 : 3'b000;
    exp_hready = 1'b1; exp_hresp = 2'b00; exp_hrdata = 32'h0;
    if (m_err_left == 2) begin
      exp_hready = 1'b0; exp_hresp = 2'b01;
    end else if (m_err_left == 1) begin
      exp_hresp = 2'b01;
    end else if (m_dslave == 0) begin
      exp_hready = rdy[0]; exp_hresp = resp[1:0]; exp_hrdata = rdata[31:0];
    end else if (m_dslave == 1) begin
      exp_hready = rdy[1]; exp_hresp = resp[3:2]; exp_hrdata = rdata[63:32];
    end else if (m_dslave == 2) begin
      exp_hready = rdy[2]; exp_hresp = resp[5:4]; exp_hrdata = rdata[95:64];
    end
    if (!rstn) begin
      m_dslave = -1; m_err_left = 0; m_stall = 0;
    end else if (m_err_left == 2) begin
      m_err_left = 1; m_stall = 0;
    end else if (exp_hready) begin
      m_dslave   = idx;
      m_err_left = (idx < 0 && (trans == 2'b10 || trans == 2'b11)) ? 2 : 0;
      m_stall    = 0;
    end else begin
`ifdef AHB_DECODE_MUX_TIMEOUT_EN
      m_stall++;
      if (m_stall == TB_TIMEOUT) begin
        m_err_left = 2; m_dslave = -1; m_stall = 0;
      end
`endif
    end
  endtask

  task automatic test_reset();
    apply_cycle(1'b0, 32'h2000_0000, 2'b10, 3'b000, 6'h3F, {3{32'hA5A5_A5A5}});
    apply_cycle(1'b0, 32'h2000_0000, 2'b10, 3'b000, 6'h3F, {3{32'hA5A5_A5A5}});
    apply_cycle(1'b1, 32'h8000_0000, 2'b00, 3'b000, 6'h3F, {3{32'hA5A5_A5A5}});
    checks++; if (bus.hready !== 1'b1) begin errors++; $display("[TB] FAIL reset_hready: got %b expected 1", bus.hready); end
    checks++; if (bus.hresp !== 2'b00) begin errors++; $display("[TB] FAIL reset_hresp: got %b expected 00", bus.hresp); end
    checks++; if (bus.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_hrdata: got %h expected 0", bus.hrdata); end
    checks++; if (bus.hsel !== 3'b000) begin errors++; $display("[TB] FAIL reset_hsel: got %b expected 000", bus.hsel); end
  endtask

  task automatic test_ram_wait();
    apply_cycle(1'b1, 32'h2000_0010, 2'b10, 3'b111, 6'h00, 96'h0);
    checks++; if (bus.hsel !== 3'b010) begin errors++; $display("[TB] FAIL ram_hsel: got %b expected 010", bus.hsel); end
    apply_cycle(1'b1, 32'h0000_0000, 2'b00, 3'b101, 6'h00, 96'h0);
    checks++; if (bus.hready !== 1'b0) begin errors++; $display("[TB] FAIL ram_wait_hready: got %b expected 0", bus.hready); end
    apply_cycle(1'b1, 32'h0000_0000, 2'b00, 3'b111, 6'h00, {32'h0, 32'hDEAD_BEEF, 32'h0});
    checks++; if (bus.hready !== 1'b1) begin errors++; $display("[TB] FAIL ram_done_hready: got %b expected 1", bus.hready); end
    checks++; if (bus.hrdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_hrdata: got %h expected deadbeef", bus.hrdata); end
    checks++; if (bus.hresp !== 2'b00) begin errors++; $display("[TB] FAIL ram_hresp: got %b expected 00", bus.hresp); end
  endtask

  task automatic test_unmapped_error();
    apply_cycle(1'b1, 32'h8000_0000, 2'b10, 3'b111, 6'h00, 96'h0);
    checks++; if (bus.hsel !== 3'b000) begin errors++; $display("[TB] FAIL unmapped_hsel: got %b expected 000", bus.hsel); end
    apply_cycle(1'b1, 32'h0000_0000, 2'b00, 3'b111, 6'h00, {3{32'hFFFF_FFFF}});
    checks++; if (bus.hready !== 1'b0 || bus.hresp !== 2'b01) begin errors++; $display("[TB] FAIL unmapped_err1: got hready=%b hresp=%b expected 0/01", bus.hready, bus.hresp); end
    checks++; if (bus.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_err1_hrdata: got %h expected 0", bus.hrdata); end
    apply_cycle(1'b1, 32'h0000_0000, 2'b00, 3'b111, 6'h00, {3{32'hFFFF_FFFF}});
    checks++; if (bus.hready !== 1'b1 || bus.hresp !== 2'b01) begin errors++; $display("[TB] FAIL unmapped_err2: got hready=%b hresp=%b expected 1/01", bus.hready, bus.hresp); end
    apply_cycle(1'b1, 32'h0000_0000, 2'b00, 3'b111, 6'h00, 96'h0);
    checks++; if (bus.hready !== 1'b1 || bus.hresp !== 2'b00) begin errors++; $display("[TB] FAIL unmapped_after: got hready=%b hresp=%b expected 1/00", bus.hready, bus.hresp); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_r [5]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic       exp_h [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] addr [5]  = '{32'h9000_0000, 32'h9000_0000, 32'h0, 32'h0, 32'h0};
    logic [1:0]  trn  [5]  = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    apply_cycle(1'b1, 32'h8000_0000, 2'b10, 3'b111, 6'h00, 96'h0);
    for (int i = 0; i < 5; i++) begin
      apply_cycle(1'b1, addr[i], trn[i], 3'b111, 6'h00, 96'h0);
      checks++;
      if (bus.hready !== exp_h[i] || bus.hresp !== exp_r[i]) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d: got hready=%b hresp=%b expected %b/%b", i, bus.hready, bus.hresp, exp_h[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_idle_unmapped();
    logic [1:0] trn [2] = '{2'b00, 2'b01};
    for (int i = 0; i < 2; i++) begin
      apply_cycle(1'b1, 32'h8000_0000, trn[i], 3'b111, 6'h00, 96'h0);
      apply_cycle(1'b1, 32'h0000_0000, 2'b00, 3'b111, 6'h3F, {3{32'hFFFF_FFFF}});
      checks++;
      if (bus.hready !== 1'b1 || bus.hresp !== 2'b00 || bus.hrdata !== 32'h0) begin
        errors++;
        $display("[TB] FAIL idle_unmapped_t%0d: got %b/%b/%h expected 1/00/0", i, bus.hready, bus.hresp, bus.hrdata);
      end
      apply_cycle(1'b1, 32'h0000_0000, 2'b00, 3'b111, 6'h00, 96'h0);
      checks++;
      if (bus.hready !== 1'b1 || bus.hresp !== 2'b00) begin
        errors++;
        $display("[TB] FAIL idle_unmapped_stay_t%0d: got %b/%b expected 1/00", i, bus.hready, bus.hresp);
      end
    end
  endtask

  task automatic test_reset_in_err1();
    apply_cycle(1'b1, 32'h8000_0000, 2'b10, 3'b111, 6'h00, 96'h0);
    apply_cycle(1'b0, 32'h8000_0000, 2'b10, 3'b111, 6'h00, {3{32'hFFFF_FFFF}});
    checks++; if (bus.hready !== 1'b0 || bus.hresp !== 2'b01) begin errors++; $display("[TB] FAIL rst_err1_pre: got %b/%b expected 0/01", bus.hready, bus.hresp); end
    apply_cycle(1'b1, 32'h8000_0000, 2'b00, 3'b000, 6'h3F, {3{32'hFFFF_FFFF}});
    checks++; if (bus.hready !== 1'b1 || bus.hresp !== 2'b00 || bus.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_err1_post: got %b/%b/%h expected 1/00/0", bus.hready, bus.hresp, bus.hrdata); end
    apply_cycle(1'b1, 32'h0000_0000, 2'b00, 3'b000, 6'h3F, {3{32'hFFFF_FFFF}});
    checks++; if (bus.hready !== 1'b1 || bus.hresp !== 2'b00 || bus.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_err1_residual: got %b/%b/%h expected 1/00/0", bus.hready, bus.hresp, bus.hrdata); end
  endtask

  task automatic test_random();
    logic [31:0] corners [8] = '{32'h0000_FFFF, 32'h0001_0000, 32'h1FFF_FFFF, 32'h2000_FFFF,
                                 32'h2001_0000, 32'h4000_0FFF, 32'h4000_1000, 32'h3FFF_FFFF};
    logic [31:0] addr;
    logic [2:0]  rdy;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       addr = corners[$urandom_range(0, 7)];
        1:       addr = {16'h0000, 16'($urandom)};
        2:       addr = {16'h2000, 16'($urandom)};
        3:       addr = {20'h40000, 12'($urandom)};
        default: addr = $urandom;
      endcase
      for (int b = 0; b < 3; b++) rdy[b] = ($urandom_range(0, 3) != 0);
      apply_cycle(($urandom_range(0, 39) != 0), addr, 2'($urandom), rdy, 6'($urandom),
                  {$urandom, $urandom, $urandom});
      checks++; if (bus.hsel !== exp_hsel) begin errors++; $display("[TB] FAIL rand_hsel n=%0d: got %b expected %b", n, bus.hsel, exp_hsel); end
      checks++; if (bus.hready !== exp_hready) begin errors++; $display("[TB] FAIL rand_hready n=%0d: got %b expected %b", n, bus.hready, exp_hready); end
      checks++; if (bus.hresp !== exp_hresp) begin errors++; $display("[TB] FAIL rand_hresp n=%0d: got %b expected %b", n, bus.hresp, exp_hresp); end
      checks++; if (bus.hrdata !== exp_hrdata) begin errors++; $display("[TB] FAIL rand_hrdata n=%0d: got %h expected %h", n, bus.hrdata, exp_hrdata); end
    end
  endtask

`ifdef AHB_DECODE_MUX_TIMEOUT_EN
  task automatic test_timeout();
    logic [95:0] pdata = {32'h1234_5678, 64'h0};
    apply_cycle(1'b0, 32'h0, 2'b00, 3'b111, 6'h00, 96'h0);
    apply_cycle(1'b1, 32'h4000_0000, 2'b10, 3'b111, 6'h00, 96'h0);
    checks++; if (bus.hsel !== 3'b100) begin errors++; $display("[TB] FAIL to_hsel: got %b expected 100", bus.hsel); end
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      apply_cycle(1'b1, 32'h8000_0000, 2'b00, 3'b011, 6'h00, pdata);
      checks++;
      if (bus.hready !== 1'b0 || bus.hresp !== 2'b00 || bus.hrdata !== 32'h1234_5678) begin
        errors++;
        $display("[TB] FAIL to_stall%0d: got %b/%b/%h expected 0/00/12345678", i, bus.hready, bus.hresp, bus.hrdata);
      end
    end
    apply_cycle(1'b1, 32'h8000_0000, 2'b00, 3'b111, 6'b10_0000, pdata);
    checks++; if (bus.hready !== 1'b0 || bus.hresp !== 2'b01 || bus.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL to_err1: got %b/%b/%h expected 0/01/0", bus.hready, bus.hresp, bus.hrdata); end
    apply_cycle(1'b1, 32'h8000_0000, 2'b00, 3'b111, 6'b10_0000, pdata);
    checks++; if (bus.hready !== 1'b1 || bus.hresp !== 2'b01 || bus.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL to_err2: got %b/%b/%h expected 1/01/0", bus.hready, bus.hresp, bus.hrdata); end
    apply_cycle(1'b1, 32'h8000_0000, 2'b00, 3'b111, 6'b10_0000, pdata);
    checks++; if (bus.hready !== 1'b1 || bus.hresp !== 2'b00 || bus.hrdata !== 32'h0) begin errors++; $display("[TB] FAIL to_late_ignored: got %b/%b/%h expected 1/00/0", bus.hready, bus.hresp, bus.hrdata); end
  endtask
`endif

  initial begin
    HRESETn           = 1'b0;
    bus.haddr         = 32'h0;
    bus.htrans        = 2'b00;
    bus.s_hready_resp = 3'b111;
    bus.s_hresp       = 6'h00;
    bus.s_hrdata      = 96'h0;
    test_reset();
    test_ram_wait();
    test_unmapped_error();
    test_back_to_back();
    test_idle_unmapped();
    test_reset_in_err1();
    test_random();
`ifdef AHB_DECODE_MUX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
